fft_mag_arbiter: RTL and testbench

Two-channel round-robin arbiter that shares one `fft_mag_sq` magnitude-squared unit between two FFT output streams. The block:
- accepts complex bins from each channel over valid/ready handshakes;
- issues at most one bin per cycle into the shared unit;
- tags each issued bin with its channel and bin index;
- re-associates each `mag_sq` result with its tag.

It sits between the two FFT cores and the spectral post-processing (peak search / accumulation).

---
 rtl/fft_mag_arbiter.sv | 131 +++++++++++++
 tb/tb_fft_mag_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_arbiter.sv
// Two-channel round-robin front end for a shared magnitude-squared unit.
// Issued bins are tagged {channel, bin}; results are re-tagged in issue order.
module fft_mag_arbiter #(
    parameter int W         = 16,
    parameter int N_BINS    = 256,
    parameter int TAG_DEPTH = 4,
    localparam int BW       = $clog2(N_BINS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          ch_valid,
    output logic [1:0]          ch_ready,
    input  logic signed [W-1:0] ch0_real,
    input  logic signed [W-1:0] ch0_imag,
    input  logic signed [W-1:0] ch1_real,
    input  logic signed [W-1:0] ch1_imag,
    output logic                fft_valid,
    output logic signed [W-1:0] fft_real,
    output logic signed [W-1:0] fft_imag,
    input  logic [2*W:0]        mag_sq,
    input  logic                mag_valid,
    output logic                out_valid,
    output logic [2*W:0]        out_mag,
    output logic                out_ch,
    output logic [BW-1:0]       out_bin,
    output logic                out_last,
    output logic                err_orphan
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic                  prio_q, prio_d;
    logic [1:0][BW-1:0]    bin_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW:0]           tag_mem [TAG_DEPTH];
    logic [BW:0]           head_tag;
    logic                  fft_valid_q, out_valid_q, out_ch_q, out_last_q, err_q;
    logic signed [W-1:0]   fft_real_q, fft_imag_q;
    logic [2*W:0]          out_mag_q;
    logic [BW-1:0]         out_bin_q;
    logic [1:0]            gnt;
    logic                  full, empty, xfer, gnt_ch, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt_q == CW'(TAG_DEPTH));
    assign empty    = (cnt_q == '0);
    assign xfer     = |gnt;
    assign gnt_ch   = gnt[1];
    assign pop      = mag_valid && !empty;
    assign head_tag = tag_mem[rd_ptr_q];

    // Full is judged on the registered count: a same-cycle pop earns no credit.
    always_comb begin
        gnt = 2'b00;
        if (!reset && !full) begin
            if (ch_valid == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
            else                   gnt = ch_valid;
        end
    end

    always_comb begin
        prio_d   = prio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(xfer) - CW'(pop);
        if (xfer) begin
            prio_d   = ~gnt_ch;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q      <= 1'b0;
            bin_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            fft_valid_q <= 1'b0;
            fft_real_q  <= '0;
            fft_imag_q  <= '0;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_ch_q    <= 1'b0;
            out_bin_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            fft_valid_q <= xfer;
            out_valid_q <= pop;
            if (xfer) begin
                fft_real_q    <= gnt_ch ? ch1_real : ch0_real;
                fft_imag_q    <= gnt_ch ? ch1_imag : ch0_imag;
                bin_q[gnt_ch] <= bin_q[gnt_ch] + 1'b1;  // N_BINS is a power of two
            end
            if (pop) begin
                out_mag_q  <= mag_sq;
                out_ch_q   <= head_tag[BW];
                out_bin_q  <= head_tag[BW-1:0];
                out_last_q <= &head_tag[BW-1:0];
            end
            if (mag_valid && empty) err_q <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (xfer) tag_mem[wr_ptr_q] <= {gnt_ch, bin_q[gnt_ch]};
    end

    assign ch_ready   = gnt;
    assign fft_valid  = fft_valid_q;
    assign fft_real   = fft_real_q;
    assign fft_imag   = fft_imag_q;
    assign out_valid  = out_valid_q;
    assign out_mag    = out_mag_q;
    assign out_ch     = out_ch_q;
    assign out_bin    = out_bin_q;
    assign out_last   = out_last_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_fft_mag_arbiter.sv
// Bench for fft_mag_arbiter: queue-based reference model, latency-L stub mag unit.
module tb_fft_mag_arbiter;
    localparam int W = 16, NB = 4, TD = 4, L = 2, BW = 2;

    logic                clk = 0, reset = 1;
    logic [1:0]          ch_valid = 0, ch_ready;
    logic signed [W-1:0] ch0_real = 0, ch0_imag = 0, ch1_real = 0, ch1_imag = 0;
    logic                fft_valid;
    logic signed [W-1:0] fft_real, fft_imag;
    logic [2*W:0]        mag_sq = 0, out_mag;
    logic                mag_valid = 0, out_valid, out_ch, out_last, err_orphan;
    logic [BW-1:0]       out_bin;

    fft_mag_arbiter #(.W(W), .N_BINS(NB), .TAG_DEPTH(TD)) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch0_real(ch0_real), .ch0_imag(ch0_imag), .ch1_real(ch1_real), .ch1_imag(ch1_imag),
        .fft_valid(fft_valid), .fft_real(fft_real), .fft_imag(fft_imag),
        .mag_sq(mag_sq), .mag_valid(mag_valid), .out_valid(out_valid), .out_mag(out_mag),
        .out_ch(out_ch), .out_bin(out_bin), .out_last(out_last), .err_orphan(err_orphan));

    always #5 clk = ~clk;

    typedef struct {bit ch; int bin; longint mag;} tag_t;
    typedef struct {longint mag; int due;} res_t;
    tag_t   tagq[$];
    res_t   stubq[$];
    longint obs_mag[$];
    int     obs_bin[$];
    bit     obs_ch[$], obs_last[$], grant_log[$];

    int  n_chk = 0, n_err = 0, cyc = 0, n_xfer = 0;
    bit  hold = 0, one_shot = 0;
    bit  prio_m, err_m, exp_fv, exp_ov, exp_ch, exp_last;
    int  bin_m[2], exp_bin;
    longint exp_re, exp_im, exp_mag;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        obs_mag.delete(); obs_bin.delete(); obs_ch.delete(); obs_last.delete();
        grant_log.delete(); n_xfer = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; ch_valid = 2'b11; mag_valid = 0;
        #1;
        chk("rst_ch_ready", ch_ready, 0);   chk("rst_fft_valid", fft_valid, 0);
        chk("rst_fft_real", fft_real, 0);   chk("rst_fft_imag", fft_imag, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_out_mag", out_mag, 0);
        chk("rst_out_ch", out_ch, 0);       chk("rst_out_bin", out_bin, 0);
        chk("rst_out_last", out_last, 0);   chk("rst_err", err_orphan, 0);
        prio_m = 0; err_m = 0; bin_m[0] = 0; bin_m[1] = 0;
        exp_fv = 0; exp_ov = 0; exp_ch = 0; exp_last = 0; exp_bin = 0;
        exp_re = 0; exp_im = 0; exp_mag = 0;
        tagq.delete(); stubq.delete(); hold = 0; one_shot = 0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 0; ch_valid = 0;
    endtask

    // One clock: drive at negedge, check ready combinationally, check registered outputs after the edge.
    task automatic step(input logic [1:0] v, input int r0, input int i0, input int r1,
                        input int i1, input bit orph);
        logic [1:0] rdy_e;
        bit gch;
        tag_t t;
        @(negedge clk);
        ch_valid = v;
        ch0_real = r0[W-1:0]; ch0_imag = i0[W-1:0];
        ch1_real = r1[W-1:0]; ch1_imag = i1[W-1:0];
        mag_valid = 0; mag_sq = 0;
        if (orph) begin
            mag_valid = 1; mag_sq = (2*W+1)'($urandom);
        end else if (stubq.size() > 0 && stubq[0].due <= cyc && (!hold || one_shot)) begin
            mag_valid = 1; mag_sq = (2*W+1)'(stubq[0].mag);
            void'(stubq.pop_front()); one_shot = 0;
        end
        #1;
        rdy_e = 2'b00;
        if (tagq.size() < TD) rdy_e = (v == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : v;
        chk("ch_ready", ch_ready, rdy_e);
        gch = rdy_e[1];
        exp_ov = mag_valid && tagq.size() > 0;
        if (mag_valid && tagq.size() == 0) err_m = 1;
        if (exp_ov) begin
            t = tagq.pop_front();
            exp_mag = t.mag; exp_ch = t.ch; exp_bin = t.bin; exp_last = (t.bin == NB - 1);
        end
        exp_fv = (rdy_e != 0);
        if (exp_fv) begin
            exp_re = gch ? longint'(ch1_real) : longint'(ch0_real);
            exp_im = gch ? longint'(ch1_imag) : longint'(ch0_imag);
            tagq.push_back('{gch, bin_m[gch], exp_re * exp_re + exp_im * exp_im});
            bin_m[gch] = (bin_m[gch] + 1) % NB;
            prio_m = !gch;
            grant_log.push_back(gch);
            n_xfer++;
        end
        @(posedge clk); #1;
        cyc++;
        chk("fft_valid", fft_valid, exp_fv);
        chk("fft_real", fft_real, exp_re);
        chk("fft_imag", fft_imag, exp_im);
        chk("out_valid", out_valid, exp_ov);
        chk("out_mag", out_mag, exp_mag);
        chk("out_ch", out_ch, exp_ch);
        chk("out_bin", out_bin, exp_bin);
        chk("out_last", out_last, exp_last);
        chk("err_orphan", err_orphan, err_m);
        if (fft_valid)
            stubq.push_back('{longint'(fft_real) * fft_real + longint'(fft_imag) * fft_imag, cyc + L});
        if (out_valid) begin
            obs_mag.push_back(out_mag); obs_ch.push_back(out_ch);
            obs_bin.push_back(out_bin); obs_last.push_back(out_last);
        end
    endtask

    task automatic rnd_step(input logic [1:0] v, input bit orph);
        step(v, $urandom, $urandom, $urandom, $urandom, orph);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Single channel
        do_reset(); clr_logs();
        step(2'b01, 23964, 29636, 0, 0, 0);
        idle(6);
        chk("t1_count", obs_mag.size(), 1);
        if (obs_mag.size() >= 1) begin
            chk("t1_mag", obs_mag[0], 64'd1452565792);
            chk("t1_ch", obs_ch[0], 0);
            chk("t1_bin", obs_bin[0], 0);
            chk("t1_last", obs_last[0], 0);
        end

        // Round-robin with both channels held valid
        do_reset(); clr_logs();
        for (int k = 0; k < 4; k++) step(2'b11, -7964, -11006, -28996, -31880, 0);
        idle(6);
        chk("t2_count", obs_mag.size(), 4);
        if (obs_mag.size() >= 4 && grant_log.size() >= 4)
            for (int k = 0; k < 4; k++) begin
                chk("t2_grant", grant_log[k], k % 2);
                chk("t2_mag", obs_mag[k], (k % 2) ? 64'd1857102416 : 64'd184557332);
                chk("t2_bin", obs_bin[k], k / 2);
            end

        // Bin wrap on channel 1
        do_reset(); clr_logs();
        for (int k = 0; k < 5; k++) rnd_step(2'b10, 0);
        idle(6);
        chk("t3_count", obs_mag.size(), 5);
        if (obs_mag.size() >= 5)
            for (int k = 0; k < 5; k++) begin
                chk("t3_bin", obs_bin[k], k % 4);
                chk("t3_last", obs_last[k], k == 3);
                chk("t3_ch", obs_ch[k], 1);
            end

        // FIFO full with the mag unit stalled
        do_reset(); clr_logs(); hold = 1;
        for (int k = 0; k < 8; k++) rnd_step(2'b11, 0);
        chk("t4_fill_xfers", n_xfer, TD);
        chk("t4_full_ready", ch_ready, 0);
        n_xfer = 0; one_shot = 1;
        for (int k = 0; k < 4; k++) rnd_step(2'b11, 0);
        chk("t4_one_pop_one_xfer", n_xfer, 1);
        n_xfer = 0; one_shot = 1;
        rnd_step(2'b11, 0);
        one_shot = 1;
        rnd_step(2'b11, 0);
        rnd_step(2'b11, 0);
        rnd_step(2'b11, 0);
        chk("t4_push_pop_xfers", n_xfer, 2);
        chk("t4_refull_ready", ch_ready, 0);
        hold = 0;
        idle(12);

        // Orphan result
        do_reset(); clr_logs();
        step(2'b00, 0, 0, 0, 0, 1);
        chk("t5_err_set", err_orphan, 1);
        idle(2);
        step(2'b10, 0, 0, 1000, -2000, 0);
        idle(6);
        chk("t5_count", obs_mag.size(), 1);
        if (obs_mag.size() >= 1) chk("t5_mag", obs_mag[0], 64'd5000000);
        chk("t5_err_sticky", err_orphan, 1);

        // Reset with tags outstanding
        do_reset(); clr_logs(); hold = 1;
        for (int k = 0; k < 3; k++) rnd_step(2'b01, 0);
        do_reset(); clr_logs();
        step(2'b11, 300, 400, 5, 5, 0);
        idle(6);
        chk("t6_count", obs_mag.size(), 1);
        if (obs_mag.size() >= 1 && grant_log.size() >= 1) begin
            chk("t6_grant", grant_log[0], 0);
            chk("t6_bin", obs_bin[0], 0);
            chk("t6_mag", obs_mag[0], 64'd250000);
        end

        // Random traffic with stalls and occasional orphans
        do_reset(); clr_logs();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) hold = !hold;
            rnd_step(2'($urandom_range(3)),
                     tagq.size() == 0 && stubq.size() == 0 && $urandom_range(29) == 0);
        end
        hold = 0;
        idle(20);
        chk("rnd_drained", tagq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
